// File: rtl/instr_sequencer.sv
// Buffers instruction words and dispatches them one at a time to the control FSM, retiring each when its terminal state is reached.
// Latency: push to code is 2 cycles min; back-to-back dispatch with no bubble; instr_ready = !full, hold stalls pop/dispatch.
module instr_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [22:0]   instr_in,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          hold,
    input  logic [4:0]    next_state,
    output logic [22:0]   code,
    output logic [4:0]    current_state,
    output logic          busy,
    output logic          done,
    output logic          illegal,
    output logic          seq_err,
    output logic [CW-1:0] retired
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state_q, state_d;
    logic [22:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, empty;
    logic [22:0]   head;
    logic [22:0]   code_d;
    logic [4:0]    cs_d;
    logic          done_d, ill_d, seq_d;
    logic [CW-1:0] ret_d;

    function automatic logic [4:0] term_of(input logic [3:0] f);
        case (f)
            4'd1:    term_of = 5'd1;
            4'd2:    term_of = 5'd2;
            4'd3:    term_of = 5'd5;
            4'd4:    term_of = 5'd9;
            4'd5:    term_of = 5'd12;
            4'd6:    term_of = 5'd15;
            4'd7:    term_of = 5'd18;
            4'd8:    term_of = 5'd21;
            4'd9:    term_of = 5'd24;
            default: term_of = 5'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] f);
        is_legal = (f != 4'd0) && (f <= 4'd9);
    endfunction

    assign empty       = (count == '0);
    assign instr_ready = (count != CNT_FULL);
    assign push        = instr_valid && instr_ready;
    assign head        = mem[rd_ptr];
    assign busy        = (state_q == EXEC);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code;
        cs_d    = current_state;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        seq_d   = 1'b0;
        ret_d   = retired;
        pop     = 1'b0;
        if (!hold) begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop = 1'b1;
                        if (is_legal(head[22:19])) begin
                            code_d  = head;
                            cs_d    = 5'd0;
                            state_d = EXEC;
                        end else begin
                            ill_d = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (current_state == term_of(code[22:19])) begin
                        done_d = 1'b1;
                        ret_d  = retired + CW'(1);
                        code_d = '0;
                        cs_d   = 5'd0;
                        if (!empty) begin
                            pop = 1'b1;
                            // Next word loads straight into code so the FSM sees no idle gap.
                            if (is_legal(head[22:19])) begin
                                code_d = head;
                            end else begin
                                ill_d   = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (next_state == 5'd0) begin
                        seq_d   = 1'b1;
                        state_d = IDLE;
                        code_d  = '0;
                        cs_d    = 5'd0;
                    end else begin
                        cs_d = next_state;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            code          <= '0;
            current_state <= 5'd0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            seq_err       <= 1'b0;
            retired       <= '0;
        end else begin
            state_q       <= state_d;
            code          <= code_d;
            current_state <= cs_d;
            done          <= done_d;
            illegal       <= ill_d;
            seq_err       <= seq_d;
            retired       <= ret_d;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: emulates the downstream FSM and checks every cycle against a queue-based model.
module tb_instr_sequencer;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [22:0]   instr_in = '0;
    logic          instr_valid = 1'b0;
    logic          hold = 1'b0;
    logic          inject = 1'b0;
    logic          instr_ready;
    logic [4:0]    next_state;
    logic [22:0]   code;
    logic [4:0]    current_state;
    logic          busy, done, illegal, seq_err;
    logic [CW-1:0] retired;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    logic [22:0]   q[$];
    logic          m_busy = 1'b0;
    logic [22:0]   m_code = '0;
    int            m_idx = 0;
    logic          m_done = 1'b0, m_ill = 1'b0, m_seq = 1'b0;
    logic [CW-1:0] m_ret = '0;

    instr_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .hold(hold), .next_state(next_state), .code(code),
        .current_state(current_state), .busy(busy), .done(done), .illegal(illegal),
        .seq_err(seq_err), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic is_legal(input logic [3:0] f);
        return (f >= 4'd1) && (f <= 4'd9);
    endfunction

    function automatic int plen(input logic [3:0] f);
        return (f == 4'd1 || f == 4'd2) ? 2 : 4;
    endfunction

    // State visited at step i of the instruction path for func f.
    function automatic logic [4:0] pstate(input logic [3:0] f, input int i);
        int t;
        case (f)
            4'd1: t = 1;   4'd2: t = 2;   4'd3: t = 5;
            4'd4: t = 9;   4'd5: t = 12;  4'd6: t = 15;
            4'd7: t = 18;  4'd8: t = 21;  4'd9: t = 24;
            default: t = 0;
        endcase
        if (i == 0) return 5'd0;
        return 5'(t - (plen(f) - 1 - i));
    endfunction

    function automatic logic [4:0] fsm_next(input logic [22:0] c, input logic [4:0] s);
        logic [3:0] f;
        f = c[22:19];
        if (!is_legal(f)) return 5'd0;
        for (int i = 0; i < plen(f) - 1; i++)
            if (pstate(f, i) == s) return pstate(f, i + 1);
        return 5'd0;
    endfunction

    assign next_state = inject ? 5'd0 : fsm_next(code, current_state);

    function automatic logic [4:0] m_cs();
        return m_busy ? pstate(m_code[22:19], m_idx) : 5'd0;
    endfunction

    function automatic logic [22:0] mkword(input logic [3:0] f);
        logic [22:0] w;
        w = 23'($urandom);
        w[22:19] = f;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    task automatic timeout(input string tag);
        n_total++;
        $display("FAIL %s: timed out at %0t", tag, $time);
    endtask

    task automatic m_load(input logic [22:0] w);
        m_code = w;
        m_idx  = 0;
        m_busy = 1'b1;
    endtask

    task automatic m_idle();
        m_busy = 1'b0;
        m_code = '0;
        m_idx  = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_idle();
        m_done = 1'b0; m_ill = 1'b0; m_seq = 1'b0;
        m_ret = '0;
    endtask

    task automatic model_step(input logic v, input logic [22:0] w, input logic h, input logic inj);
        logic        do_push;
        logic [22:0] hw;
        do_push = v && (q.size() < DEPTH);
        m_done = 1'b0; m_ill = 1'b0; m_seq = 1'b0;
        if (!h) begin
            if (!m_busy) begin
                if (q.size() > 0) begin
                    hw = q.pop_front();
                    if (is_legal(hw[22:19])) m_load(hw);
                    else m_ill = 1'b1;
                end
            end else if (m_idx == plen(m_code[22:19]) - 1) begin
                m_done = 1'b1;
                m_ret  = m_ret + CW'(1);
                if (q.size() > 0) begin
                    hw = q.pop_front();
                    if (is_legal(hw[22:19])) m_load(hw);
                    else begin m_ill = 1'b1; m_idle(); end
                end else m_idle();
            end else if (inj) begin
                m_seq = 1'b1;
                m_idle();
            end else m_idx++;
        end
        if (do_push) q.push_back(w);
    endtask

    task automatic compare_all();
        check("code", 32'(code), 32'(m_busy ? m_code : 23'd0));
        check("state", 32'(current_state), 32'(m_cs()));
        check("flags", 32'({busy, done, illegal, seq_err, instr_ready}),
              32'({m_busy, m_done, m_ill, m_seq, (q.size() < DEPTH)}));
        check("retired", 32'(retired), 32'(m_ret));
    endtask

    task automatic cyc(input logic v, input logic [22:0] w, input logic h, input logic inj);
        instr_valid = v; instr_in = w; hold = h; inject = inj;
        model_step(v, w, h, inj);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) cyc(1'b0, 23'd0, h, 1'b0);
    endtask

    initial begin
        logic [3:0]  f;
        logic        found;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single load
        cyc(1'b1, mkword(4'd1), 1'b0, 1'b0);
        idle(8, 1'b0);
        // add then sub back-to-back
        cyc(1'b1, mkword(4'd3), 1'b0, 1'b0);
        cyc(1'b1, mkword(4'd4), 1'b0, 1'b0);
        idle(12, 1'b0);
        // Illegal func 1100
        cyc(1'b1, mkword(4'd12), 1'b0, 1'b0);
        idle(4, 1'b0);
        // Overfill while held, then release
        for (int i = 0; i <= DEPTH; i++)
            cyc(1'b1, mkword(4'($urandom_range(1, 9))), 1'b1, 1'b0);
        idle(3, 1'b1);
        idle(30, 1'b0);
        // Premature return to state 0 from state 3 of an add
        cyc(1'b1, mkword(4'd3), 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_busy && m_cs() == 5'd3) begin
                cyc(1'b0, 23'd0, 1'b0, 1'b1);
                found = 1'b1;
            end else idle(1, 1'b0);
        end
        if (!found) timeout("seq_err_setup");
        idle(3, 1'b0);

        // Random traffic; CW=4 makes retired wrap several times
        for (int i = 0; i < 3000; i++) begin
            f = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) :
                ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
            cyc(1'($urandom_range(0, 2) != 0), mkword(f),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 24) == 0));
        end
        idle(40, 1'b0);

        // Asynchronous reset during the second cycle of a divide
        cyc(1'b1, mkword(4'd8), 1'b0, 1'b0);
        cyc(1'b1, mkword(4'd3), 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_busy && m_idx == 1) found = 1'b1;
            else idle(1, 1'b0);
        end
        if (!found) timeout("div_setup");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
